// File: rtl/conv_layer_seq_pkg.sv
// Shared configuration for the convolution layer sequencer: widths, table depth, states, descriptor.
package conv_layer_seq_pkg;

  localparam int unsigned TENSOR_W   = 8;
  localparam int unsigned KERNEL_W   = 4;
  localparam int unsigned CHANNELS_W = 8;
  localparam int unsigned STRIDE_W   = 3;
  localparam int unsigned KNUMS_W    = 8;
  localparam int unsigned MAX_LAYERS = 4;
  localparam int unsigned LIDX_W     = (MAX_LAYERS > 1) ? $clog2(MAX_LAYERS) : 1;
  localparam int unsigned NLAY_W     = LIDX_W + 1;
  localparam int unsigned IFMAP_W    = 2 * TENSOR_W + KNUMS_W;

  // One-hot sequencer states
  typedef enum logic [5:0] {
    ST_IDLE  = 6'b000001,
    ST_CHECK = 6'b000010,
    ST_CALC  = 6'b000100,
    ST_MUL   = 6'b001000,
    ST_RUN   = 6'b010000,
    ST_DONE  = 6'b100000
  } state_e;

  // One kernel descriptor in the layer table
  typedef struct packed {
    logic [KERNEL_W-1:0] kernel_size;
    logic [STRIDE_W-1:0] stride;
    logic [KNUMS_W-1:0]  kernel_nums;
  } desc_t;

endpackage

// File: rtl/conv_dim_div.sv
// Restoring divider for the output-side computation; one quotient bit per cycle.
// The load edge already performs the first iteration, so valid is seen DW cycles after load.
module conv_dim_div #(
  parameter int unsigned DW = 8,
  parameter int unsigned SW = 3
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          load,
  input  logic [DW-1:0] dividend,
  input  logic [SW-1:0] divisor,
  output logic [DW-1:0] quotient,
  output logic          valid
);

  localparam int unsigned CW = $clog2(DW + 1);

  logic [SW-1:0] rem_q;
  logic [DW-1:0] quo_q;
  logic [CW-1:0] cnt_q;
  logic          valid_q;

  // Single restoring step: shift in next dividend bit, subtract if it fits
  function automatic logic [SW+DW-1:0] div_step(input logic [SW-1:0] r,
                                                 input logic [DW-1:0] q,
                                                 input logic [SW-1:0] d);
    logic [SW:0] trial;
    logic        qbit;
    trial = {r, q[DW-1]};
    qbit  = 1'b0;
    if (trial >= {1'b0, d}) begin
      trial = trial - {1'b0, d};
      qbit  = 1'b1;
    end
    return {trial[SW-1:0], q[DW-2:0], qbit};
  endfunction

  // Iteration register: remainder, shifting quotient, and remaining-step counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else if (load) begin
      {rem_q, quo_q} <= div_step('0, dividend, divisor);
      cnt_q          <= CW'(DW - 1);
      valid_q        <= (DW == 1);
    end else if (cnt_q != '0) begin
      {rem_q, quo_q} <= div_step(rem_q, quo_q, divisor);
      cnt_q          <= cnt_q - CW'(1);
      valid_q        <= (cnt_q == CW'(1));
    end
  end

  assign quotient = quo_q;
  assign valid    = valid_q;

endmodule

// File: rtl/conv_layer_seq.sv
// Multi-layer convolution sequencer: walks a descriptor table, validates geometry,
// derives output size, drives the conv datapath and chains layer outputs to inputs.
module conv_layer_seq
  import conv_layer_seq_pkg::*;
(
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  enable,
  input  logic                  start,
  input  logic [NLAY_W-1:0]     num_layers,
  input  logic [TENSOR_W-1:0]   axi_tensor_size,
  input  logic [CHANNELS_W-1:0] axi_channels,
  input  logic                  cfg_we,
  input  logic [LIDX_W-1:0]     cfg_addr,
  input  logic [KERNEL_W-1:0]   cfg_kernel_size,
  input  logic [STRIDE_W-1:0]   cfg_stride,
  input  logic [KNUMS_W-1:0]    cfg_kernel_nums,
  input  logic                  w_done,
  output logic [TENSOR_W-1:0]   tensor_size,
  output logic [KERNEL_W-1:0]   kernel_size,
  output logic [CHANNELS_W-1:0] channels,
  output logic [STRIDE_W-1:0]   stride,
  output logic [KNUMS_W-1:0]    kernel_nums,
  output logic [TENSOR_W-1:0]   ofs,
  output logic [IFMAP_W-1:0]    ifmap_num,
  output logic [LIDX_W-1:0]     layer_idx,
  output logic                  start_conv,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err
);

  state_e state_q, state_n;

  logic [TENSOR_W-1:0]   ts_q, ts_n;
  logic [KERNEL_W-1:0]   ks_q, ks_n;
  logic [CHANNELS_W-1:0] ch_q, ch_n;
  logic [STRIDE_W-1:0]   st_q, st_n;
  logic [KNUMS_W-1:0]    kn_q, kn_n;
  logic [TENSOR_W-1:0]   ofs_q, ofs_n;
  logic [IFMAP_W-1:0]    ifm_q, ifm_n;
  logic [LIDX_W-1:0]     lidx_q, lidx_n;
  logic [NLAY_W-1:0]     nlay_q, nlay_n;
  logic                  sc_q, sc_n, busy_q, busy_n, done_q, done_n, err_q, err_n;

  desc_t                 desc_tbl_q [MAX_LAYERS];
  desc_t                 cfg_desc_c, desc0_c, next_desc_c;
  logic                  cfg_wr_c, geom_bad_c, div_load_c, div_valid;
  logic [TENSOR_W-1:0]   div_quot, ofs_c;

  assign cfg_desc_c  = '{kernel_size: cfg_kernel_size, stride: cfg_stride, kernel_nums: cfg_kernel_nums};
  assign cfg_wr_c    = cfg_we && !busy_q;
  // A write in the start cycle must be visible to the descriptor latched at start
  assign desc0_c     = (cfg_wr_c && cfg_addr == '0) ? cfg_desc_c : desc_tbl_q[0];
  assign next_desc_c = desc_tbl_q[LIDX_W'(lidx_q + LIDX_W'(1))];
  assign geom_bad_c  = (st_q == '0) || (ks_q == '0) || (TENSOR_W'(ks_q) > ts_q) ||
                       (nlay_q == '0) || (nlay_q > NLAY_W'(MAX_LAYERS));
  assign ofs_c       = div_quot + TENSOR_W'(1);

  conv_dim_div #(.DW(TENSOR_W), .SW(STRIDE_W)) u_div (
    .clk      (clk),
    .rstn     (rstn),
    .load     (div_load_c),
    .dividend (ts_q - TENSOR_W'(ks_q)),
    .divisor  (st_q),
    .quotient (div_quot),
    .valid    (div_valid)
  );

  // Descriptor table; writes only land while the sequencer is not busy
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < int'(MAX_LAYERS); i++) desc_tbl_q[i] <= '0;
    end else if (cfg_wr_c) begin
      desc_tbl_q[cfg_addr] <= cfg_desc_c;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_n;
  end

  // Next state, divider load and next values of all registered outputs
  always_comb begin
    state_n    = state_q;
    ts_n       = ts_q;
    ks_n       = ks_q;
    ch_n       = ch_q;
    st_n       = st_q;
    kn_n       = kn_q;
    ofs_n      = ofs_q;
    ifm_n      = ifm_q;
    lidx_n     = lidx_q;
    nlay_n     = nlay_q;
    err_n      = err_q;
    div_load_c = 1'b0;
    if (!enable) begin
      state_n = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (start) begin
          state_n = ST_CHECK;
          ts_n    = axi_tensor_size;
          ch_n    = axi_channels;
          nlay_n  = num_layers;
          ks_n    = desc0_c.kernel_size;
          st_n    = desc0_c.stride;
          kn_n    = desc0_c.kernel_nums;
          lidx_n  = '0;
          err_n   = 1'b0;
        end
        ST_CHECK: if (geom_bad_c) begin
          err_n   = 1'b1;
          state_n = ST_IDLE;
        end else begin
          div_load_c = 1'b1;
          state_n    = ST_CALC;
        end
        ST_CALC: if (div_valid) state_n = ST_MUL;
        ST_MUL: begin
          ofs_n   = ofs_c;
          ifm_n   = IFMAP_W'(ofs_c) * IFMAP_W'(ofs_c) * IFMAP_W'(kn_q);
          state_n = ST_RUN;
        end
        ST_RUN: if (w_done) begin
          if ({1'b0, lidx_q} == nlay_q - NLAY_W'(1)) begin
            state_n = ST_DONE;
          end else begin
            lidx_n  = lidx_q + LIDX_W'(1);
            ts_n    = ofs_q;
            ch_n    = CHANNELS_W'(kn_q);
            ks_n    = next_desc_c.kernel_size;
            st_n    = next_desc_c.stride;
            kn_n    = next_desc_c.kernel_nums;
            state_n = ST_CHECK;
          end
        end
        ST_DONE: state_n = ST_IDLE;
        default: state_n = ST_IDLE;
      endcase
    end
    sc_n   = (state_n == ST_RUN);
    busy_n = !((state_n == ST_IDLE) || (state_n == ST_DONE));
    done_n = (state_n == ST_DONE);
  end

  // Output and parameter registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ts_q   <= '0;
      ks_q   <= '0;
      ch_q   <= '0;
      st_q   <= '0;
      kn_q   <= '0;
      ofs_q  <= '0;
      ifm_q  <= '0;
      lidx_q <= '0;
      nlay_q <= '0;
      sc_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      ts_q   <= ts_n;
      ks_q   <= ks_n;
      ch_q   <= ch_n;
      st_q   <= st_n;
      kn_q   <= kn_n;
      ofs_q  <= ofs_n;
      ifm_q  <= ifm_n;
      lidx_q <= lidx_n;
      nlay_q <= nlay_n;
      sc_q   <= sc_n;
      busy_q <= busy_n;
      done_q <= done_n;
      err_q  <= err_n;
    end
  end

  assign tensor_size = ts_q;
  assign kernel_size = ks_q;
  assign channels    = ch_q;
  assign stride      = st_q;
  assign kernel_nums = kn_q;
  assign ofs         = ofs_q;
  assign ifmap_num   = ifm_q;
  assign layer_idx   = lidx_q;
  assign start_conv  = sc_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign cfg_err     = err_q;

endmodule

// File: tb/tb_conv_layer_seq.sv
// Directed bench for conv_layer_seq with a layer-level arithmetic model.
module tb_conv_layer_seq;
  import conv_layer_seq_pkg::*;

  logic                  clk, rstn, enable, start, cfg_we, w_done;
  logic [NLAY_W-1:0]     num_layers;
  logic [TENSOR_W-1:0]   axi_tensor_size;
  logic [CHANNELS_W-1:0] axi_channels;
  logic [LIDX_W-1:0]     cfg_addr;
  logic [KERNEL_W-1:0]   cfg_kernel_size;
  logic [STRIDE_W-1:0]   cfg_stride;
  logic [KNUMS_W-1:0]    cfg_kernel_nums;
  logic [TENSOR_W-1:0]   tensor_size, ofs;
  logic [KERNEL_W-1:0]   kernel_size;
  logic [CHANNELS_W-1:0] channels;
  logic [STRIDE_W-1:0]   stride;
  logic [KNUMS_W-1:0]    kernel_nums;
  logic [IFMAP_W-1:0]    ifmap_num;
  logic [LIDX_W-1:0]     layer_idx;
  logic                  start_conv, busy, done, cfg_err;

  conv_layer_seq dut (
    .clk(clk), .rstn(rstn), .enable(enable), .start(start), .num_layers(num_layers),
    .axi_tensor_size(axi_tensor_size), .axi_channels(axi_channels),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_kernel_size(cfg_kernel_size),
    .cfg_stride(cfg_stride), .cfg_kernel_nums(cfg_kernel_nums), .w_done(w_done),
    .tensor_size(tensor_size), .kernel_size(kernel_size), .channels(channels),
    .stride(stride), .kernel_nums(kernel_nums), .ofs(ofs), .ifmap_num(ifmap_num),
    .layer_idx(layer_idx), .start_conv(start_conv), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Model: bench copy of the descriptor table and expected per-layer results
  int tbl_k [MAX_LAYERS], tbl_s [MAX_LAYERS], tbl_kn [MAX_LAYERS];
  int e_t [MAX_LAYERS], e_c [MAX_LAYERS], e_k [MAX_LAYERS], e_s [MAX_LAYERS];
  int e_kn [MAX_LAYERS], e_ofs [MAX_LAYERS], e_ifm [MAX_LAYERS];
  int e_nvalid;
  bit e_err;
  int g_t [MAX_LAYERS], g_c [MAX_LAYERS], g_k [MAX_LAYERS], g_ofs [MAX_LAYERS];
  int g_ifm [MAX_LAYERS], g_idx [MAX_LAYERS];
  int m_cur = 0;
  bit m_active = 1'b0;

  function automatic void model_seq(input int t0, input int c0, input int n);
    int t, c, o;
    t = t0; c = c0; e_err = 1'b0; e_nvalid = 0;
    if (n < 1 || n > int'(MAX_LAYERS)) begin e_err = 1'b1; return; end
    for (int i = 0; i < n; i++) begin
      if (tbl_s[i] == 0 || tbl_k[i] == 0 || tbl_k[i] > t) begin e_err = 1'b1; return; end
      o = (t - tbl_k[i]) / tbl_s[i] + 1;
      e_t[i] = t; e_c[i] = c; e_k[i] = tbl_k[i]; e_s[i] = tbl_s[i]; e_kn[i] = tbl_kn[i];
      e_ofs[i] = o; e_ifm[i] = o * o * tbl_kn[i];
      e_nvalid = i + 1;
      t = o; c = tbl_kn[i];
    end
  endfunction

  // Whenever the datapath is told to run, outputs must describe the model's current layer
  always begin
    @(posedge clk); #1;
    if (start_conv === 1'b1) begin
      if (!m_active || m_cur >= e_nvalid) begin
        chk("start_conv_unexpected", 32'(start_conv), 0);
      end else begin
        chk("run_tensor", 32'(tensor_size), e_t[m_cur]);
        chk("run_channels", 32'(channels), e_c[m_cur]);
        chk("run_kernel", 32'(kernel_size), e_k[m_cur]);
        chk("run_stride", 32'(stride), e_s[m_cur]);
        chk("run_knums", 32'(kernel_nums), e_kn[m_cur]);
        chk("run_ofs", 32'(ofs), e_ofs[m_cur]);
        chk("run_ifmap", 32'(ifmap_num), e_ifm[m_cur]);
        chk("run_layer_idx", 32'(layer_idx), m_cur);
        chk("run_busy", 32'(busy), 1);
        chk("run_done", 32'(done), 0);
      end
    end
  end

  task automatic cfg_write(input int a, input int k, input int s, input int kn);
    cfg_we = 1'b1; cfg_addr = LIDX_W'(a); cfg_kernel_size = KERNEL_W'(k);
    cfg_stride = STRIDE_W'(s); cfg_kernel_nums = KNUMS_W'(kn);
    tbl_k[a] = k; tbl_s[a] = s; tbl_kn[a] = kn;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // inj: 0 none, 1 cfg write while busy, 2 enable drop in CALC,
  //      3 spurious w_done in CALC + start in RUN, 4 cfg write in the start cycle
  task automatic run_seq(input int t0, input int c0, input int n, input int inj);
    int cnt;
    bit seen;
    bit last;
    if (inj == 4) begin
      cfg_we = 1'b1; cfg_addr = '0; cfg_kernel_size = 4; cfg_stride = 2; cfg_kernel_nums = 2;
      tbl_k[0] = 4; tbl_s[0] = 2; tbl_kn[0] = 2;
    end
    model_seq(t0, c0, n);
    m_cur = 0;
    m_active = (e_nvalid > 0);
    start = 1'b1; axi_tensor_size = TENSOR_W'(t0); axi_channels = CHANNELS_W'(c0);
    num_layers = NLAY_W'(n);
    @(negedge clk);
    start = 1'b0; cfg_we = 1'b0;
    chk("busy_e0", 32'(busy), 1);
    @(negedge clk);
    chk("cfg_err_e1", 32'(cfg_err), 32'(e_err && e_nvalid == 0));
    if (e_err && e_nvalid == 0) begin
      @(negedge clk);
      chk("err_busy_e2", 32'(busy), 0);
      chk("err_start_conv_e2", 32'(start_conv), 0);
      repeat (12) @(negedge clk);
      return;
    end
    for (int L = 0; L < e_nvalid; L++) begin
      m_cur = L;
      cnt = (L == 0) ? 2 : 1;
      seen = 1'b0;
      while (!seen && cnt < 40) begin
        if (start_conv === 1'b1) begin
          seen = 1'b1;
        end else begin
          if (L == 0 && cnt == 5) begin
            case (inj)
              1: begin
                cfg_we = 1'b1; cfg_addr = '0; cfg_kernel_size = 7; cfg_stride = 1; cfg_kernel_nums = 4;
              end
              2: enable = 1'b0;
              3: w_done = 1'b1;
              default: ;
            endcase
          end
          if (L == 0 && cnt == 6) begin
            cfg_we = 1'b0; w_done = 1'b0;
            if (inj == 2) begin
              enable = 1'b1;
              chk("abort_busy", 32'(busy), 0);
              chk("abort_start_conv", 32'(start_conv), 0);
              chk("abort_done", 32'(done), 0);
              chk("abort_kernel_hold", 32'(kernel_size), e_k[0]);
              m_active = 1'b0;
              repeat (15) @(negedge clk);
              chk("abort_stays_idle", 32'(busy), 0);
              return;
            end
          end
          @(negedge clk);
          cnt++;
        end
      end
      chk("start_conv_latency", cnt, TENSOR_W + 3);
      if (!seen) begin m_active = 1'b0; return; end
      g_t[L] = int'(tensor_size); g_c[L] = int'(channels); g_k[L] = int'(kernel_size);
      g_ofs[L] = int'(ofs); g_ifm[L] = int'(ifmap_num); g_idx[L] = int'(layer_idx);
      @(negedge clk);
      if (inj == 3 && L == 0) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("run_holds_start_conv", 32'(start_conv), 1);
      chk("run_holds_layer", 32'(layer_idx), L);
      w_done = 1'b1;
      @(negedge clk);
      w_done = 1'b0;
      last = (L == e_nvalid - 1) && !e_err;
      if (last) begin
        chk("done_pulse", 32'(done), 1);
        chk("done_busy", 32'(busy), 0);
        chk("done_start_conv", 32'(start_conv), 0);
        chk("done_ofs_hold", 32'(ofs), e_ofs[L]);
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 0);
      end else begin
        chk("gap_start_conv_drop", 32'(start_conv), 0);
      end
    end
    m_active = 1'b0;
    if (e_err) begin
      @(negedge clk);
      chk("late_cfg_err", 32'(cfg_err), 1);
      repeat (3) @(negedge clk);
    end
  endtask

  initial begin
    rstn = 1'b0; enable = 1'b1; start = 1'b0; cfg_we = 1'b0; w_done = 1'b0;
    num_layers = '0; axi_tensor_size = '0; axi_channels = '0; cfg_addr = '0;
    cfg_kernel_size = '0; cfg_stride = '0; cfg_kernel_nums = '0;
    for (int i = 0; i < int'(MAX_LAYERS); i++) begin tbl_k[i] = 0; tbl_s[i] = 0; tbl_kn[i] = 0; end
    repeat (2) @(negedge clk);
    chk("rst_tensor", 32'(tensor_size), 0);
    chk("rst_ofs", 32'(ofs), 0);
    chk("rst_ifmap", 32'(ifmap_num), 0);
    chk("rst_flags", 32'({start_conv, busy, done, cfg_err}), 0);
    rstn = 1'b1;

    cfg_write(0, 3, 1, 4);
    cfg_write(1, 2, 2, 8);

    // Single layer
    run_seq(8, 3, 1, 0);
    chk("pin_l0_ofs", g_ofs[0], 6);
    chk("pin_l0_ifmap", g_ifm[0], 144);
    chk("pin_l0_channels", g_c[0], 3);

    // Two-layer chain
    run_seq(8, 3, 2, 0);
    chk("pin_l1_tensor", g_t[1], 6);
    chk("pin_l1_channels", g_c[1], 4);
    chk("pin_l1_ofs", g_ofs[1], 3);
    chk("pin_l1_ifmap", g_ifm[1], 72);
    chk("pin_l1_idx", g_idx[1], 1);

    // Geometry errors
    cfg_write(0, 5, 1, 4);
    run_seq(4, 3, 1, 0);
    chk("pin_err_k_gt_t", 32'(cfg_err), 1);
    cfg_write(0, 3, 0, 4);
    run_seq(8, 3, 1, 0);
    chk("pin_err_s0", 32'(cfg_err), 1);
    cfg_write(0, 3, 1, 4);
    run_seq(8, 3, 0, 0);
    chk("pin_err_n0", 32'(cfg_err), 1);

    // Write while busy is dropped; readback run still sees K=3
    run_seq(8, 3, 1, 1);
    chk("pin_busy_wr_k", g_k[0], 3);
    run_seq(8, 3, 1, 0);
    chk("pin_readback_k", g_k[0], 3);
    chk("pin_readback_ofs", g_ofs[0], 6);

    // Enable drop in CALC, then fresh restart from layer 0
    run_seq(8, 3, 1, 2);
    run_seq(8, 3, 2, 0);
    chk("pin_restart_l0_tensor", g_t[0], 8);
    chk("pin_restart_l1_ofs", g_ofs[1], 3);

    // Spurious w_done in IDLE
    w_done = 1'b1;
    @(negedge clk);
    w_done = 1'b0;
    @(negedge clk);
    chk("idle_wdone_done", 32'(done), 0);
    chk("idle_wdone_busy", 32'(busy), 0);
    run_seq(8, 3, 1, 3);

    // Write in the start cycle is used by that run
    run_seq(8, 3, 1, 4);
    chk("pin_samecyc_k", g_k[0], 4);
    chk("pin_samecyc_ofs", g_ofs[0], 3);
    chk("pin_samecyc_ifmap", g_ifm[0], 18);

    // Asynchronous reset mid-sequence clears outputs and the table
    start = 1'b1; axi_tensor_size = 8; num_layers = 1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_tensor", 32'(tensor_size), 0);
    chk("midrst_kernel", 32'(kernel_size), 0);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < int'(MAX_LAYERS); i++) begin tbl_k[i] = 0; tbl_s[i] = 0; tbl_kn[i] = 0; end
    run_seq(8, 3, 1, 0);
    chk("pin_table_cleared_err", 32'(cfg_err), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_layer_seq.md
# conv_layer_seq

Multi-layer convolution sequencer for the IMG2COL/GEMM datapath. It holds a programmable table of up to MAX_LAYERS kernel descriptors and runs them back to back from one start pulse. For each layer it validates the geometry and computes the output feature size with a fixed-latency divider. It then drives the conv datapath with latched per-layer parameters, and chains each layer's output size and channel count into the next layer's input.

## Interface
- TENSOR_W, 8, tensor side width
- KERNEL_W, 4, kernel side width
- CHANNELS_W, 8, channel count width
- STRIDE_W, 3, stride width
- KNUMS_W, 8, kernel count width
- MAX_LAYERS, 4, descriptor table depth; LIDX_W = $clog2(MAX_LAYERS), minimum 1
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- enable  in  1  global enable; low forces IDLE synchronously
- start  in  1  one-cycle pulse, begins a layer sequence
- num_layers  in  LIDX_W+1  layers to run; sampled on start
- axi_tensor_size  in  TENSOR_W  layer-0 input side; sampled on start
- axi_channels  in  CHANNELS_W  layer-0 input channels; sampled on start
- cfg_we  in  1  descriptor write strobe
- cfg_addr  in  LIDX_W  descriptor index
- cfg_kernel_size  in  KERNEL_W  descriptor kernel side
- cfg_stride  in  STRIDE_W  descriptor stride
- cfg_kernel_nums  in  KNUMS_W  descriptor kernel count
- w_done  in  1  datapath finished current layer; one-cycle pulse
- tensor_size  out  TENSOR_W  current layer input side
- kernel_size  out  KERNEL_W  current layer kernel side
- channels  out  CHANNELS_W  current layer input channels
- stride  out  STRIDE_W  current layer stride
- kernel_nums  out  KNUMS_W  current layer kernel count
- ofs  out  TENSOR_W  output side, (T-K)/S+1
- ifmap_num  out  2*TENSOR_W+KNUMS_W  ofs*ofs*kernel_nums
- layer_idx  out  LIDX_W  index of the active layer
- start_conv  out  1  datapath run level
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  one-cycle pulse at end of sequence
- cfg_err  out  1  sticky; invalid geometry detected

## Operation
- All outputs and the descriptor table reset to 0.
- States: IDLE, CHECK, CALC, MUL, RUN, DONE. Encoding is one-hot.
- IDLE:
  - start & enable → CHECK.
  - Latch T=axi_tensor_size, C=axi_channels, num_layers, and descriptor 0.
  - Set layer_idx=0 and clear cfg_err.
- CHECK:
  - Invalid geometry is any of: S==0, K==0, K>T, num_layers==0, or num_layers>MAX_LAYERS.
  - On invalid geometry: set cfg_err, go to IDLE, and leave start_conv low.
  - Otherwise load the divider with T-K and S, then go to CALC.
- CALC: the restoring divider runs exactly TENSOR_W iterations, then → MUL.
- MUL: register ofs=quotient+1 and ifmap_num=ofs*ofs*kernel_nums at full width, with no truncation; then → RUN.
- RUN:
  - start_conv=1.
  - On w_done, start_conv drops at that edge.
  - If layer_idx==num_layers-1 → DONE.
  - Otherwise increment layer_idx, set tensor_size←ofs and channels←kernel_nums, load the next descriptor, and go to CHECK.
- DONE: done=1 for one cycle, then → IDLE. Outputs keep the last layer's values.
- cfg_we is accepted only while busy==0. Writes while busy are dropped.
- start while busy is ignored. w_done outside RUN is ignored.
- enable low in any state:
  - Go to IDLE next edge and clear start_conv, busy, and done.
  - Parameter outputs and cfg_err hold.
- Reset mid-sequence: everything returns to reset values immediately, including the table.

## Timing
- The start-sampling edge is e0. CHECK occupies e0→e1, CALC e1→e(TENSOR_W+1), MUL e(TENSOR_W+1)→e(TENSOR_W+2).
- start_conv rises on e(TENSOR_W+2).
- cfg_err rises on e1.
- Inter-layer gap: start_conv is low for TENSOR_W+2 cycles between layers.
- done pulses on the edge following the final w_done.
- A cfg write and a start in the same cycle: the write lands first, so the new descriptor is used.

## Structure
- Shared config include holds:
  - default widths;
  - MAX_LAYERS;
  - one-hot state localparams.
- Sub-module conv_dim_div: TENSOR_W-bit restoring divider with a STRIDE_W divisor.
  - Ports: load, dividend, divisor, quotient, valid.
  - Fixed latency of TENSOR_W cycles.
- The descriptor table is a flop array inside conv_layer_seq.

## Test plan
- Single layer: T=8, K=3, S=1, knums=4, C=3 → ofs=6, ifmap_num=144, start_conv rises at e10, done one cycle after w_done.
- Two-layer chain: L0 T=8, K=3, S=1, knums=4; L1 K=2, S=2, knums=8 → L1 tensor_size=6, channels=4, ofs=3, ifmap_num=72, layer_idx=1.
- Errors:
  - K=5 with T=4 → cfg_err at e1, no start_conv, busy low at e2.
  - S=0 → cfg_err.
  - num_layers=0 → cfg_err.
- cfg_we while busy with new kernel_size=7 → ignored; sequence uses the old value, and a readback run after done shows the old descriptor.
- enable dropped during CALC → IDLE next edge, start_conv stays 0; a later start restarts from layer 0.
- Spurious w_done in IDLE or CALC, plus start during RUN → no state change, no done.
